// File: rtl/stream_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | stream_fifo                                                             |
// | First-word-fall-through valid/ready FIFO with fill-level output.        |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module stream_fifo #(
    parameter int DW = 0,  // instantiator must set DW >= 1
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [AW:0]   cnt_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    logic w_empty;
    logic w_full;
    logic w_wr_en;
    logic w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign w_wr_en = s_valid_i && !w_full;
    assign w_rd_en = !w_empty && m_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; contents are only visible behind m_valid_o.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data_i;
        end
    end

    assign s_ready_o = !w_full;
    assign m_valid_o = !w_empty;
    assign m_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_o     = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire
